// File: rtl/gent_constrained_rand_gen.sv
// Constrained-random value generator: a 32-bit LFSR supplies candidates that
// must fall inside every enabled range policy, retried up to MAX_TRIES times.
module gent_constrained_rand_gen #(
  parameter int          WIDTH        = 16,
  parameter int          NUM_POLICIES = 4,
  parameter int          MAX_TRIES    = 64,
  parameter logic [31:0] SEED         = 32'h0000_0001,
  localparam int         IW = (NUM_POLICIES > 1) ? $clog2(NUM_POLICIES) : 1,
  localparam int         TW = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IW-1:0]    cfg_idx,
  input  logic             cfg_en,
  input  logic [WIDTH-1:0] cfg_min,
  input  logic [WIDTH-1:0] cfg_max,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [TW-1:0]    out_tries,
  output logic             busy
);

  localparam logic [31:0] SEED_I = (SEED == 32'h0) ? 32'h1 : SEED;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [TW-1:0]    otries_q, otries_d;

  logic             en_q  [NUM_POLICIES];
  logic             en_d  [NUM_POLICIES];
  logic [WIDTH-1:0] min_q [NUM_POLICIES];
  logic [WIDTH-1:0] min_d [NUM_POLICIES];
  logic [WIDTH-1:0] max_q [NUM_POLICIES];
  logic [WIDTH-1:0] max_d [NUM_POLICIES];

  logic [31:0]      lfsr_nxt;
  logic [WIDTH-1:0] cand;
  logic             legal;
  logic [TW-1:0]    tries_inc;

  assign lfsr_nxt  = {lfsr_q[30:0],
                      lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign cand      = lfsr_q[WIDTH-1:0];
  assign tries_inc = tries_q + 1'b1;

  // Intersection of all enabled ranges; an inverted range never passes.
  always_comb begin
    legal = 1'b1;
    for (int i = 0; i < NUM_POLICIES; i++) begin
      if (en_q[i] && ((cand < min_q[i]) || (cand > max_q[i]))) begin
        legal = 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    tries_d  = tries_q;
    data_d   = data_q;
    err_d    = err_q;
    otries_d = otries_q;
    en_d     = en_q;
    min_d    = min_q;
    max_d    = max_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          for (int i = 0; i < NUM_POLICIES; i++) begin
            if (cfg_idx == IW'(i)) begin
              en_d[i]  = cfg_en;
              min_d[i] = cfg_min;
              max_d[i] = cfg_max;
            end
          end
        end
        if (req_valid) begin
          state_d = S_SEARCH;
          tries_d = '0;
        end
      end
      S_SEARCH: begin
        lfsr_d  = lfsr_nxt;
        tries_d = tries_inc;
        if (legal) begin
          state_d  = S_HOLD;
          data_d   = cand;
          err_d    = 1'b0;
          otries_d = tries_inc;
        end else if (tries_inc == TW'(MAX_TRIES)) begin
          state_d  = S_HOLD;
          data_d   = '0;
          err_d    = 1'b1;
          otries_d = TW'(MAX_TRIES);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_I;
      tries_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      otries_q <= '0;
      for (int i = 0; i < NUM_POLICIES; i++) begin
        en_q[i]  <= 1'b0;
        min_q[i] <= '0;
        max_q[i] <= '1;
      end
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      tries_q  <= tries_d;
      data_q   <= data_d;
      err_q    <= err_d;
      otries_q <= otries_d;
      en_q     <= en_d;
      min_q    <= min_d;
      max_q    <= max_d;
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign out_tries = otries_q;

endmodule

// File: tb/tb_gent_constrained_rand_gen.sv
// Directed vector bench for gent_constrained_rand_gen: default instance plus a
// MAX_TRIES=4 / NUM_POLICIES=3 instance selected through a shared bus.
module tb_gent_constrained_rand_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic        cfg_valid = 1'b0, req_valid = 1'b0, out_ready = 1'b0;
  logic        cfg_en = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [15:0] cfg_min = '0, cfg_max = '0;

  logic a_cv, a_rv, a_or, b_cv, b_rv, b_or;
  assign a_cv = cfg_valid & ~sel;
  assign a_rv = req_valid & ~sel;
  assign a_or = out_ready & ~sel;
  assign b_cv = cfg_valid & sel;
  assign b_rv = req_valid & sel;
  assign b_or = out_ready & sel;

  logic        a_cfg_ready, a_req_ready, a_out_valid, a_out_err, a_busy;
  logic [15:0] a_out_data;
  logic [6:0]  a_out_tries;
  logic        b_cfg_ready, b_req_ready, b_out_valid, b_out_err, b_busy;
  logic [15:0] b_out_data;
  logic [2:0]  b_out_tries;

  gent_constrained_rand_gen dut_a (
    .clk(clk), .rst(rst),
    .cfg_valid(a_cv), .cfg_ready(a_cfg_ready), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .req_valid(a_rv), .req_ready(a_req_ready),
    .out_valid(a_out_valid), .out_ready(a_or),
    .out_data(a_out_data), .out_err(a_out_err),
    .out_tries(a_out_tries), .busy(a_busy)
  );

  gent_constrained_rand_gen #(
    .NUM_POLICIES(3), .MAX_TRIES(4)
  ) dut_b (
    .clk(clk), .rst(rst),
    .cfg_valid(b_cv), .cfg_ready(b_cfg_ready), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .req_valid(b_rv), .req_ready(b_req_ready),
    .out_valid(b_out_valid), .out_ready(b_or),
    .out_data(b_out_data), .out_err(b_out_err),
    .out_tries(b_out_tries), .busy(b_busy)
  );

  logic        m_cfg_ready, m_req_ready, m_out_valid, m_out_err, m_busy;
  logic [15:0] m_out_data;
  logic [6:0]  m_out_tries;
  assign m_cfg_ready = sel ? b_cfg_ready : a_cfg_ready;
  assign m_req_ready = sel ? b_req_ready : a_req_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_err   = sel ? b_out_err : a_out_err;
  assign m_busy      = sel ? b_busy : a_busy;
  assign m_out_data  = sel ? b_out_data : a_out_data;
  assign m_out_tries = sel ? {4'd0, b_out_tries} : a_out_tries;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, 32'(m_out_valid), 32'd0);
    chk({nm, "_busy"}, 32'(m_busy), 32'd0);
    chk({nm, "_cfg_ready"}, 32'(m_cfg_ready), 32'd1);
    chk({nm, "_req_ready"}, 32'(m_req_ready), 32'd1);
    chk({nm, "_data"}, 32'(m_out_data), 32'd0);
    chk({nm, "_err"}, 32'(m_out_err), 32'd0);
    chk({nm, "_tries"}, 32'(m_out_tries), 32'd0);
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drive an optional config write together with an optional request,
  // then wait (bounded) for the result and consume it.
  task automatic run_req(input string nm, input bit cv,
                         input logic [1:0] idx, input bit en,
                         input logic [15:0] mn, input logic [15:0] mx,
                         input bit rq, output logic [31:0] d,
                         output logic [31:0] e, output logic [31:0] t,
                         output int lat);
    d = '0; e = '0; t = '0; lat = 0;
    cfg_valid = cv;
    cfg_idx   = idx;
    cfg_en    = en;
    cfg_min   = mn;
    cfg_max   = mx;
    req_valid = rq;
    @(negedge clk);
    cfg_valid = 1'b0;
    req_valid = 1'b0;
    if (rq) begin
      chk({nm, "_busy"}, 32'(m_busy), 32'd1);
      chk({nm, "_req_ready"}, 32'(m_req_ready), 32'd0);
      lat = 1;
      while (!m_out_valid && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      if (!m_out_valid) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: out_valid never rose in %0d cycles",
                 nm, lat);
      end
      d = 32'(m_out_data);
      e = 32'(m_out_err);
      t = 32'(m_out_tries);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({nm, "_release"}, 32'(m_out_valid), 32'd0);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          cv;
    logic [1:0]  idx;
    bit          en;
    logic [15:0] mn;
    logic [15:0] mx;
    bit          rq;
    logic [15:0] d;
    bit          e;
    int          t;
  } vec_t;

  localparam int NV = 7;
  vec_t v [NV];

  initial begin
    logic [31:0] d, e, t, s;
    int lat;

    s = 32'h1;
    repeat (64) s = step(s);

    v[0] = '{1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0001, 1'b0, 1};
    v[1] = '{1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0003, 1'b0, 1};
    v[2] = '{1'b1, 1'b1, 2'd0, 1'b1, 16'h4, 16'h7, 1'b1, 16'h0006, 1'b0, 3};
    v[3] = '{1'b1, 1'b1, 2'd2, 1'b1, 16'h9, 16'h2, 1'b1, 16'h0000, 1'b1, 64};
    v[4] = '{1'b0, 1'b1, 2'd2, 1'b0, 16'h9, 16'h2, 1'b1, s[15:0], 1'b0, 1};
    v[5] = '{1'b1, 1'b1, 2'd3, 1'b1, 16'h10, 16'hFFFF, 1'b0, 16'h0, 1'b0, 0};
    v[6] = '{1'b0, 1'b1, 2'd1, 1'b1, 16'h0, 16'h20, 1'b1, 16'h001B, 1'b0, 5};

    do_reset();
    chk_idle("reset_a");

    for (int i = 0; i < NV; i++) begin
      if (v[i].rst) do_reset();
      run_req($sformatf("v%0d", i), v[i].cv, v[i].idx, v[i].en,
              v[i].mn, v[i].mx, v[i].rq, d, e, t, lat);
      if (v[i].rq) begin
        chk($sformatf("v%0d_data", i), d, 32'(v[i].d));
        chk($sformatf("v%0d_err", i), e, 32'(v[i].e));
        chk($sformatf("v%0d_tries", i), t, 32'(v[i].t));
        chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].t + 1));
      end
    end

    // Back-pressure: result held, requests and config writes refused.
    do_reset();
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_first_valid", 32'(m_out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      req_valid = 1'b1;
      cfg_valid = 1'b1;
      cfg_idx   = 2'd0;
      cfg_en    = 1'b1;
      cfg_min   = 16'h9;
      cfg_max   = 16'h2;
      @(negedge clk);
      chk($sformatf("bp%0d_valid", k), 32'(m_out_valid), 32'd1);
      chk($sformatf("bp%0d_data", k), 32'(m_out_data), 32'h1);
      chk($sformatf("bp%0d_tries", k), 32'(m_out_tries), 32'd1);
      chk($sformatf("bp%0d_req_ready", k), 32'(m_req_ready), 32'd0);
      chk($sformatf("bp%0d_cfg_ready", k), 32'(m_cfg_ready), 32'd0);
    end
    req_valid = 1'b0;
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(m_out_valid), 32'd0);
    chk("bp_release_busy", 32'(m_busy), 32'd0);
    run_req("bp_next", 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b1, d, e, t, lat);
    chk("bp_next_data", d, 32'h3);
    chk("bp_next_err", e, 32'd0);

    // Asynchronous reset in the second SEARCH cycle.
    do_reset();
    cfg_valid = 1'b1;
    cfg_idx   = 2'd2;
    cfg_en    = 1'b1;
    cfg_min   = 16'h9;
    cfg_max   = 16'h2;
    req_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(m_busy), 32'd1);
    #1 rst = 1'b1;
    #1 chk_idle("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_req("post_rst", 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b1, d, e, t, lat);
    chk("post_rst_data", d, 32'h1);
    chk("post_rst_tries", t, 32'd1);
    chk("post_rst_err", e, 32'd0);

    // Small instance: exhausted tries, then out-of-range index ignored.
    sel = 1'b1;
    do_reset();
    chk_idle("reset_b");
    run_req("b_exh", 1'b1, 2'd1, 1'b1, 16'h5, 16'h5, 1'b1, d, e, t, lat);
    chk("b_exh_data", d, 32'h0);
    chk("b_exh_err", e, 32'd1);
    chk("b_exh_tries", t, 32'd4);
    chk("b_exh_latency", 32'(lat), 32'd5);
    do_reset();
    run_req("b_oob", 1'b1, 2'd3, 1'b1, 16'h5, 16'h5, 1'b1, d, e, t, lat);
    chk("b_oob_data", d, 32'h1);
    chk("b_oob_err", e, 32'd0);
    chk("b_oob_tries", t, 32'd1);
    sel = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gent_constrained_rand_gen.md
Name: gent_constrained_rand_gen

Overview:
- Hardware constrained-random value generator.
- A 32-bit LFSR produces candidate values. A candidate is accepted only when it satisfies every enabled range policy (intersection semantics). Rejected candidates are retried up to a bounded number of attempts.
- Sits beside stimulus and traffic engines that need legal random operands on demand. Policies are programmed through a simple config port; requests and results use valid/ready handshakes.

Parameters:
- WIDTH, 16: generated value width. Legal range 1..32.
- NUM_POLICIES, 4: number of independent range policies. Must be >= 1.
- MAX_TRIES, 64: candidates evaluated per request before giving up. Must be >= 1.
- SEED, 32'h0000_0001: LFSR reset value. 0 is illegal and is forced to 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  policy write request
- cfg_ready  out  1  policy write accepted; high only in IDLE
- cfg_idx  in  max(1,$clog2(NUM_POLICIES))  policy index
- cfg_en  in  1  policy enable
- cfg_min  in  WIDTH  inclusive lower bound, unsigned
- cfg_max  in  WIDTH  inclusive upper bound, unsigned
- req_valid  in  1  request one value
- req_ready  out  1  request accepted
- out_valid  out  1  result available
- out_ready  in  1  result consumed
- out_data  out  WIDTH  generated value
- out_err  out  1  no legal value found within MAX_TRIES
- out_tries  out  $clog2(MAX_TRIES+1)  candidates evaluated for this result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, lfsr=SEED (or 1 if SEED==0).
  - All policies: en=0, min=0, max=all-ones.
  - out_valid=0, out_data=0, out_err=0, out_tries=0, busy=0.
  - cfg_ready=1, req_ready=1.
- Reset mid-SEARCH or mid-HOLD: the result is dropped, nothing is emitted, policies return to reset values.
- Config write:
  - Occurs when cfg_valid && cfg_ready.
  - Writes en/min/max of policy cfg_idx at the clock edge.
  - cfg_idx >= NUM_POLICIES: the write is ignored but the handshake still completes.
  - Enabling a policy with min > max is legal; that policy is unsatisfiable.
- Policy i passes candidate c when !en[i] || (min[i] <= c && c <= max[i]). The candidate is legal when all policies pass.
- LFSR:
  - Fibonacci, polynomial x^32+x^22+x^2+x+1.
  - Next state = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
  - Advances only on SEARCH cycles; the state is held in IDLE and HOLD across requests.
  - Candidate = lfsr[WIDTH-1:0] of the current (pre-advance) state.
- FSM:
  - IDLE: req_ready=1, cfg_ready=1.
    - req_valid -> SEARCH, tries=0.
    - A config write and a request in the same cycle are both accepted; the new policy is in effect for the first candidate.
  - SEARCH: evaluate one candidate per cycle, advance the LFSR, tries+1.
    - Legal candidate -> HOLD with out_data=candidate, out_err=0, out_tries=tries+1.
    - Else, if tries+1 == MAX_TRIES -> HOLD with out_data=0, out_err=1, out_tries=MAX_TRIES.
    - Else stay in SEARCH.
  - HOLD: out_valid=1; out_data, out_err and out_tries are stable.
    - out_ready -> IDLE, out_valid=0 next cycle.
    - A new request is not accepted in the same cycle.
- Latency: request accepted at edge N; first candidate evaluated in cycle N+1; out_valid asserted from edge N+2 at best, and N+1+MAX_TRIES at worst.
- Throughput: at most one result per 3 cycles.
- out_ready held high before out_valid has no effect.
- req_valid while busy is ignored (req_ready=0); no queuing.
- out_tries counter never wraps: its width covers MAX_TRIES.

Test Plan:
- Default params, no policies, reset then a request -> out_data=16'h0001, out_tries=1, out_err=0, out_valid at edge N+2. A second request -> out_data=16'h0003.
- Policy 0 = [4,7] enabled, fresh reset, one request -> candidates 1, 3, 6 -> out_data=16'h0006, out_tries=3, out_err=0.
- MAX_TRIES=4, policy 1 = [5,5] enabled, fresh reset -> candidates 1, 3, 6, 0xD all fail -> out_err=1, out_data=0, out_tries=4.
- Policy 2 enabled with min=9, max=2 -> out_err=1 after MAX_TRIES=64 candidates. A rewrite with en=0, then a request -> a legal value is produced.
- Back-pressure: hold out_ready=0 for 10 cycles in HOLD -> out_valid, out_data and out_tries stable, req_ready=0, cfg_ready=0, LFSR unchanged. Then raise out_ready -> IDLE next cycle.
- Assert rst in SEARCH cycle 2 -> outputs at reset values immediately (async), policies cleared. The next request after release reproduces out_data=16'h0001.
